// File: rtl/sfp_pkg.sv
// Shared definitions for the sfp arithmetic blocks: packed word layout, limits
// and small helpers used by both the adder and the normaliser.
package sfp_pkg;

    localparam int SFP_W    = 26;
    localparam int EXP_W    = 8;
    localparam int FRA_W    = 17;
    localparam int EXP_BIAS = 127;
    localparam int EXP_MAX  = 254;

    localparam int SIGN_BIT = SFP_W - 1;
    localparam int EXP_MSB  = SFP_W - 2;
    localparam int EXP_LSB  = FRA_W;
    localparam int FRA_MSB  = FRA_W - 1;
    localparam int FRA_LSB  = 0;

    // Magnitude of the adder sum: hidden one at FRA_W plus one carry bit.
    localparam int MAG_W    = FRA_W + 2;
    localparam int POS_W    = 5;

    typedef logic [SFP_W-1:0] sfp_t;

    localparam sfp_t SFP_ZERO = '0;

    function automatic sfp_t sat_word(input logic sign);
        sfp_t w;
        w                   = '0;
        w[SIGN_BIT]         = sign;
        w[EXP_MSB:EXP_LSB]  = EXP_W'(EXP_MAX);
        w[FRA_MSB:FRA_LSB]  = '1;
        return w;
    endfunction

    function automatic sfp_t sfp_pack(input logic sign,
                                      input logic [EXP_W-1:0] expo,
                                      input logic [FRA_W-1:0] frac);
        return {sign, expo, frac};
    endfunction

endpackage

// File: rtl/sfp_lzd.sv
// Combinational leading-one detector for the normaliser magnitude.
// Reports the bit index of the most significant set bit and a zero flag.
module sfp_lzd
    import sfp_pkg::*;
(
    input  logic [MAG_W-1:0] mag,
    output logic [POS_W-1:0] pos,
    output logic             zero
);

    logic [MAG_W-1:0] lead;

    // One-hot marker of the leading one: a bit wins only if nothing above it is set.
    generate
        for (genvar gi = 0; gi < MAG_W; gi++) begin : g_lead
            if (gi == MAG_W - 1) begin : g_top
                assign lead[gi] = mag[gi];
            end else begin : g_rest
                assign lead[gi] = mag[gi] & ~(|mag[MAG_W-1:gi+1]);
            end
        end
    endgenerate

    always_comb begin
        pos = '0;
        for (int i = 0; i < MAG_W; i++) begin
            if (lead[i]) begin
                pos = pos | POS_W'(i);
            end
        end
    end

    assign zero = ~(|mag);

endmodule

// File: rtl/sfp_norm.sv
// Three-stage normalise/round stage behind sfp_add: magnitude, leading-one
// search, then shift or round-to-nearest-even with saturation and flush-to-zero.
module sfp_norm #(
    parameter int FRA_W   = 17,
    parameter int EXP_W   = 8,
    parameter int EXP_MAX = 254
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_req,
    input  logic [EXP_W-1:0]       i_exp,
    input  logic [FRA_W+2:0]       i_sum,
    output logic                   o_vld,
    output logic [FRA_W+EXP_W:0]   o_do,
    output logic                   o_ovf,
    output logic                   o_unf
);

    import sfp_pkg::sfp_t;
    import sfp_pkg::SFP_ZERO;
    import sfp_pkg::sat_word;
    import sfp_pkg::sfp_pack;

    localparam int SUM_W = FRA_W + 3;
    localparam int MAG_W = FRA_W + 2;
    localparam int POS_W = 5;
    localparam int E_W   = EXP_W + 2;

    // ---------------- P1: sign / magnitude ----------------
    logic             p1_vld_reg;
    logic             p1_sign_reg;
    logic [MAG_W-1:0] p1_mag_reg;
    logic [EXP_W-1:0] p1_exp_reg;
    logic [MAG_W-1:0] mag_next;

    assign mag_next = i_sum[SUM_W-1] ? MAG_W'(-i_sum) : i_sum[MAG_W-1:0];

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            p1_vld_reg  <= 1'b0;
            p1_sign_reg <= 1'b0;
            p1_mag_reg  <= '0;
            p1_exp_reg  <= '0;
        end else begin
            p1_vld_reg <= i_req;
            if (i_req) begin
                p1_sign_reg <= i_sum[SUM_W-1];
                p1_mag_reg  <= mag_next;
                p1_exp_reg  <= i_exp;
            end
        end
    end

    // ---------------- P2: leading one and new exponent ----------------
    logic             p2_vld_reg;
    logic             p2_sign_reg;
    logic             p2_zero_reg;
    logic [MAG_W-1:0] p2_mag_reg;
    logic [POS_W-1:0] p2_pos_reg;
    logic [E_W-1:0]   p2_e_reg;
    logic [POS_W-1:0] lzd_pos;
    logic             lzd_zero;
    logic [E_W-1:0]   e_next;

    sfp_lzd u_lzd (
        .mag  (p1_mag_reg),
        .pos  (lzd_pos),
        .zero (lzd_zero)
    );

    // Two's-complement in E_W bits; range -17..256 fits without overflow.
    assign e_next = E_W'(p1_exp_reg) + E_W'(lzd_pos) - E_W'(FRA_W);

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            p2_vld_reg  <= 1'b0;
            p2_sign_reg <= 1'b0;
            p2_zero_reg <= 1'b0;
            p2_mag_reg  <= '0;
            p2_pos_reg  <= '0;
            p2_e_reg    <= '0;
        end else begin
            p2_vld_reg <= p1_vld_reg;
            if (p1_vld_reg) begin
                p2_sign_reg <= p1_sign_reg;
                p2_zero_reg <= lzd_zero;
                p2_mag_reg  <= p1_mag_reg;
                p2_pos_reg  <= lzd_pos;
                p2_e_reg    <= e_next;
            end
        end
    end

    // ---------------- P3: shift / round, range check ----------------
    logic             on_top;
    logic [FRA_W:0]   rnd_sum;
    logic [POS_W-1:0] shamt;
    logic [FRA_W-1:0] frac_sh;
    logic [FRA_W-1:0] frac_next;
    logic [E_W-1:0]   e_fin;
    sfp_t             do_next;
    logic             ovf_next;
    logic             unf_next;

    assign on_top  = (p2_pos_reg == POS_W'(MAG_W - 1));
    // Only one bit drops off, so guard alone decides; ties go to the even lsb.
    assign rnd_sum = {1'b0, p2_mag_reg[FRA_W:1]}
                   + (FRA_W+1)'(p2_mag_reg[0] & p2_mag_reg[1]);
    assign shamt   = POS_W'(FRA_W) - p2_pos_reg;
    assign frac_sh = FRA_W'(p2_mag_reg << shamt);

    always_comb begin
        frac_next = frac_sh;
        e_fin     = p2_e_reg;
        if (on_top) begin
            frac_next = rnd_sum[FRA_W-1:0];
            e_fin     = p2_e_reg + E_W'(rnd_sum[FRA_W]);
        end
    end

    always_comb begin
        do_next  = SFP_ZERO;
        ovf_next = 1'b0;
        unf_next = 1'b0;
        if (p2_zero_reg) begin
            do_next = SFP_ZERO;
        end else if (e_fin[E_W-1] || (e_fin == '0)) begin
            unf_next = 1'b1;
        end else if (e_fin > E_W'(EXP_MAX)) begin
            do_next  = sat_word(p2_sign_reg);
            ovf_next = 1'b1;
        end else begin
            do_next = sfp_pack(p2_sign_reg, e_fin[EXP_W-1:0], frac_next);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            o_vld <= 1'b0;
            o_do  <= '0;
            o_ovf <= 1'b0;
            o_unf <= 1'b0;
        end else begin
            o_vld <= p2_vld_reg;
            if (p2_vld_reg) begin
                o_do  <= do_next;
                o_ovf <= ovf_next;
                o_unf <= unf_next;
            end
        end
    end

endmodule

// File: tb/tb_sfp_norm.sv
// Self-checking bench for sfp_norm: directed corner values, random streaming
// against an arithmetic reference model, and asynchronous reset mid-flight.
module tb_sfp_norm;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b0;
    logic        i_req = 1'b0;
    logic [7:0]  i_exp = '0;
    logic [19:0] i_sum = '0;
    logic        o_vld;
    logic [25:0] o_do;
    logic        o_ovf;
    logic        o_unf;

    always #5 i_clk = ~i_clk;

    sfp_norm dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_req (i_req),
        .i_exp (i_exp),
        .i_sum (i_sum),
        .o_vld (o_vld),
        .o_do  (o_do),
        .o_ovf (o_ovf),
        .o_unf (o_unf)
    );

    typedef struct packed {
        logic        vld;
        logic [7:0]  e_in;
        logic [19:0] s_in;
        logic [25:0] word;
        logic        ovf;
        logic        unf;
    } exp_t;

    exp_t        pend[$];
    logic [25:0] held_do;
    logic        held_ovf;
    logic        held_unf;
    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_txn    = 0;

    // Reference: value = sum * 2^(exp-144); renormalise by plain arithmetic.
    function automatic exp_t model(input logic [7:0] e_in, input logic [19:0] s);
        exp_t r;
        int   v, m, e, keep;
        logic sgn;
        r      = '0;
        r.vld  = 1'b1;
        r.e_in = e_in;
        r.s_in = s;
        v      = int'($signed(s));
        sgn    = (v < 0);
        m      = sgn ? -v : v;
        if (m == 0) return r;
        e = int'(e_in);
        if (m >= (1 << 18)) begin
            keep = m / 2;
            e    = e + 1;
            if ((m % 2) == 1 && (keep % 2) == 1) keep = keep + 1;
            if (keep == (1 << 18)) begin
                keep = keep / 2;
                e    = e + 1;
            end
        end else begin
            keep = m;
            while (keep < (1 << 17)) begin
                keep = keep * 2;
                e    = e - 1;
            end
        end
        if (e <= 0) begin
            r.unf = 1'b1;
        end else if (e > 254) begin
            r.ovf  = 1'b1;
            r.word = {sgn, 8'd254, 17'h1FFFF};
        end else begin
            r.word = {sgn, 8'(e), 17'(keep - (1 << 17))};
        end
        return r;
    endfunction

    function automatic exp_t fixed(input logic [7:0] e_in, input logic [19:0] s,
                                   input logic [25:0] w, input logic ovf, input logic unf);
        exp_t r;
        r      = '0;
        r.vld  = 1'b1;
        r.e_in = e_in;
        r.s_in = s;
        r.word = w;
        r.ovf  = ovf;
        r.unf  = unf;
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_checks++;
        assert (obs === want) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    // One clock: drive on negedge, then check the result due from two calls earlier.
    task automatic step(input logic req, input exp_t want);
        exp_t x;
        exp_t w;
        w       = want;
        w.vld   = req;
        i_req   = req;
        i_exp   = want.e_in;
        i_sum   = want.s_in;
        pend.push_back(w);
        @(posedge i_clk);
        @(negedge i_clk);
        if (pend.size() >= 3) begin
            x = pend.pop_front();
            check("o_vld", 32'(o_vld), 32'(x.vld));
            if (x.vld) begin
                n_txn++;
                check("o_do", 32'(o_do), 32'(x.word));
                check("o_ovf", 32'(o_ovf), 32'(x.ovf));
                check("o_unf", 32'(o_unf), 32'(x.unf));
                $display("txn %0d: exp=%h sum=%h -> do=%h ovf=%b unf=%b (want %h %b %b)",
                         n_txn, x.e_in, x.s_in, o_do, o_ovf, o_unf, x.word, x.ovf, x.unf);
                held_do  = x.word;
                held_ovf = x.ovf;
                held_unf = x.unf;
            end else begin
                check("hold_do", 32'(o_do), 32'(held_do));
                check("hold_flags", 32'({o_ovf, o_unf}), 32'({held_ovf, held_unf}));
            end
        end
    endtask

    task automatic restart_model();
        exp_t idle;
        idle = '0;
        pend.delete();
        pend.push_back(idle);
        pend.push_back(idle);
        held_do  = '0;
        held_ovf = 1'b0;
        held_unf = 1'b0;
    endtask

    initial begin
        exp_t        idle;
        logic [7:0]  re;
        logic [19:0] rs;
        idle = '0;

        // Reset state
        repeat (2) @(posedge i_clk);
        #1;
        check("rst_vld", 32'(o_vld), 32'd0);
        check("rst_do", 32'(o_do), 32'd0);
        check("rst_flags", 32'({o_ovf, o_unf}), 32'd0);
        @(negedge i_clk);
        i_rst = 1'b1;
        restart_model();

        // Directed values
        step(1'b1, fixed(8'h7F, 20'h20000, 26'h0FE0000, 1'b0, 1'b0));
        step(1'b0, idle);
        step(1'b0, idle);
        step(1'b1, fixed(8'h7F, 20'h60000, 26'h1010000, 1'b0, 1'b0));
        step(1'b1, fixed(8'h7F, 20'h7FFFF, 26'h1020000, 1'b0, 1'b0));
        step(1'b1, fixed(8'h7F, 20'hFFFFF, 26'h2DC0000, 1'b0, 1'b0));
        step(1'b1, fixed(8'h7F, 20'h00000, 26'h0000000, 1'b0, 1'b0));
        step(1'b1, fixed(8'h05, 20'h00001, 26'h0000000, 1'b0, 1'b1));
        step(1'b1, fixed(8'hFE, 20'h40000, 26'h1FDFFFF, 1'b1, 1'b0));
        step(1'b1, fixed(8'h7F, 20'h20003, 26'h0FE0003, 1'b0, 1'b0));
        step(1'b1, fixed(8'h11, 20'h00001, 26'h0000000, 1'b0, 1'b1));
        step(1'b1, fixed(8'h12, 20'h00001, 26'h0020000, 1'b0, 1'b0));
        step(1'b1, fixed(8'h7F, 20'h40001, 26'h1000000, 1'b0, 1'b0));
        step(1'b1, fixed(8'h7F, 20'h40003, 26'h1000002, 1'b0, 1'b0));
        step(1'b0, idle);
        step(1'b0, idle);
        step(1'b0, idle);
        step(1'b0, idle);

        // Random streaming, back to back
        for (int i = 0; i < 10; i++) begin
            re = 8'($urandom_range(0, 255));
            rs = 20'($urandom);
            if (rs == 20'h80000) rs = 20'h00000;
            step(1'b1, model(re, rs));
        end
        // Small magnitudes and extreme exponents to reach the flush/saturate edges
        for (int i = 0; i < 12; i++) begin
            re = (i % 2 == 0) ? 8'($urandom_range(0, 20)) : 8'($urandom_range(236, 255));
            rs = 20'($signed(21'($urandom_range(0, 2047)) - 21'd1024));
            if (i % 3 == 0) rs = 20'($urandom);
            if (rs == 20'h80000) rs = 20'h00000;
            step(1'b1, model(re, rs));
        end
        step(1'b0, idle);
        step(1'b0, idle);

        // Asynchronous reset while results are in flight
        step(1'b1, model(8'h80, 20'h3ABCD));
        step(1'b1, model(8'h81, 20'hC1234));
        step(1'b1, model(8'h82, 20'h25555));
        i_req = 1'b0;
        i_rst = 1'b0;
        #1;
        check("arst_vld", 32'(o_vld), 32'd0);
        check("arst_do", 32'(o_do), 32'd0);
        check("arst_flags", 32'({o_ovf, o_unf}), 32'd0);
        @(posedge i_clk);
        #1;
        check("arst_hold_vld", 32'(o_vld), 32'd0);
        @(negedge i_clk);
        i_rst = 1'b1;
        restart_model();
        for (int i = 0; i < 5; i++) step(1'b0, idle);

        // Pipeline still functional after reset
        step(1'b1, fixed(8'h7F, 20'h20000, 26'h0FE0000, 1'b0, 1'b0));
        step(1'b1, model(8'h90, 20'hFFF00));
        step(1'b0, idle);
        step(1'b0, idle);
        step(1'b0, idle);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sfp_norm.md
Name: sfp_norm

Overview:
- Normalise/round stage directly downstream of sfp_add.
- Takes the raw aligned two's-complement mantissa sum and common exponent from the adder datapath, and emits a packed 26-bit sfp word.
- Fully pipelined: one result per cycle, fixed latency, no back-pressure.
- sfp format: [25] sign, [24:17] exponent (bias 127), [16:0] fraction with hidden 1.
  - Exponent 0 encodes zero (no denormals).
  - Exponent 255 is reserved and never produced.

Parameters:
- FRA_W, 17, stored fraction width.
- EXP_W, 8, exponent width.
- EXP_MAX, 254, largest exponent emitted; saturation target.

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst  input  1  asynchronous active-low reset.
- i_req  input  1  input sample valid.
- i_exp  input  EXP_W  common (larger) exponent from adder alignment.
- i_sum  input  FRA_W+3 (20)  signed mantissa sum; hidden-one weight at bit 17; value = i_sum * 2^(i_exp-127-17).
- o_vld  output  1  result valid, one-cycle pulse per accepted i_req.
- o_do  output  26  packed sfp result.
- o_ovf  output  1  result saturated; qualified by o_vld.
- o_unf  output  1  nonzero result flushed to zero; qualified by o_vld.

Behaviour:
- Reset (async, i_rst=0): all stage valids, o_vld, o_do, o_ovf and o_unf go to 0 immediately. In-flight samples are discarded; no result emerges after reset release for requests issued before it.
- Latency: i_req at edge N gives o_vld=1 after edge N+3. Back-to-back requests give back-to-back results in order.
- Data registers load only when their stage valid is set. o_do, o_ovf and o_unf hold their last value while o_vld=0.
- P1: sign = i_sum[19]; mag[18:0] = |i_sum|. -2^19 cannot occur from sfp_add, so no handling is required for it.
- P2: leading-one position pos (0..18) of mag; zero flag if mag==0. Unbiased new exponent e = i_exp + pos - 17, computed signed 10-bit.
- P3, case pos==18: frac = mag[17:1]; guard = mag[0]. Round-to-nearest-even: increment iff guard & mag[1]. If the increment carries out of the fraction, frac=0 and e=e+1.
- P3, case pos<18: left shift by 17-pos; exact, no rounding.
- Zero input: o_do=0, o_ovf=0, o_unf=0, sign forced 0.
- e<=0 and mag!=0: o_do=0, o_unf=1.
- e>EXP_MAX after rounding: o_do={sign,EXP_MAX,all-ones fraction}, o_ovf=1.
- Otherwise: o_do={sign,e[7:0],frac}, both flags 0.
- i_exp=0 with nonzero sum is treated arithmetically like any other exponent.
- No internal state beyond the pipeline; no FSM. Stage valid chain: p1_vld<=i_req, p2_vld<=p1_vld, o_vld<=p2_vld.

Decomposition:
- Shared package sfp_pkg:
  - SFP_W=26, EXP_W, FRA_W, EXP_BIAS=127, EXP_MAX.
  - SFP_ZERO constant.
  - Field-position constants (sign bit, exponent slice, fraction slice).
  - sat_word(sign) helper.
  - sfp_add also uses this package.
- Sub-module sfp_lzd: combinational leading-one detector. Inputs 19-bit mag; outputs 5-bit pos and zero flag. Instantiated in P2.

Test Plan:
- Unit value: i_exp=8'h7F, i_sum=20'h20000, i_req pulse -> 3 cycles later o_vld=1, o_do=26'h0FE0000, flags 0.
- Carry and round-to-even:
  - i_exp=8'h7F, i_sum=20'h60000 -> o_do=26'h1010000 (3.0).
  - Next cycle, i_sum=20'h7FFFF -> o_do=26'h1020000 (rounded up to 4.0, exponent bump).
- Cancellation/negative: i_exp=8'h7F, i_sum=20'hFFFFF (-1 ulp) -> o_do=26'h2DC0000 (sign 1, exp 8'h6E, frac 0).
- Zero/underflow:
  - i_sum=0 -> o_do=0, o_unf=0.
  - i_exp=8'h05, i_sum=20'h00001 -> o_do=0, o_unf=1.
- Overflow: i_exp=8'hFE, i_sum=20'h40000 -> o_do=26'h1FDFFFF, o_ovf=1.
- Streaming + reset:
  - 10 consecutive random requests -> 10 consecutive o_vld, matching a reference model in order.
  - Drive i_rst low for one cycle while 2 requests are in flight -> o_vld/o_do read 0 asynchronously, and no stale o_vld appears afterward.
